uart_param: RTL
===============

# uart_param

Parametrised UART with runtime baud divisor, configurable data width, optional parity and 1/2 stop bits. Each direction has an integrated FIFO. The RX FIFO stores per-character error flags alongside the data. It is the drop-in successor to the fixed 8N1 UART and sits between a register/bus front end and the chip pins.

## Interface
- DATA_BITS, 8: character width, legal 5..8.
- FIFO_DEPTH, 8: entries per FIFO, power of two, ≥2.
- DIV_WIDTH, 16: width of the runtime divisor.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- i_div  in  DIV_WIDTH  oversample divisor; oversample tick every i_div+1 clk; 16 ticks per bit.
- i_parity_en  in  1  append/check a parity bit.
- i_parity_odd  in  1  1 = odd parity, 0 = even.
- i_stop2  in  1  TX sends two stop bits.
- i_txfifo_wen  in  1  push i_txfifo_wdata.
- i_txfifo_wdata  in  DATA_BITS  TX character.
- o_txfifo_full  out  1  TX FIFO full.
- o_txfifo_cnt  out  $clog2(FIFO_DEPTH)+1  TX occupancy.
- i_rxfifo_ren  in  1  pop RX head.
- o_rxfifo_empty  out  1  RX FIFO empty.
- o_rxfifo_rdata  out  DATA_BITS  RX head data (show-ahead).
- o_rxfifo_rerr  out  2  RX head flags: [1] frame error, [0] parity error.
- o_rxfifo_cnt  out  $clog2(FIFO_DEPTH)+1  RX occupancy.
- o_rx_overrun  out  1  sticky; a character was dropped because the RX FIFO was full.
- i_err_clr  in  1  clears o_rx_overrun.
- o_tx_busy  out  1  TX engine not idle.
- o_tx  out  1  serial out.
- i_rx  in  1  serial in, asynchronous.

## Operation
- FIFOs: a write when full is ignored and leaves the contents unchanged. A read when empty is ignored. rdata/rerr show the head whenever not empty and are 0 when empty. Pointers wrap modulo FIFO_DEPTH. A simultaneous read and write when full, or when empty, performs only the legal operation. A simultaneous read and write otherwise leaves cnt unchanged.
- Config latch: i_div, i_parity_en, i_parity_odd and i_stop2 are captured at frame start, separately by the TX and RX engines. Changes mid-frame affect the next frame only.
- TX FSM: IDLE → START → DATA → PARITY (skipped if parity disabled) → STOP → IDLE.
  - Leaving IDLE pops the TX FIFO in the same cycle.
  - Data is sent LSB first. Parity is the XOR of the data bits, inverted when odd parity is selected.
  - STOP lasts 1 or 2 bit times.
  - TX owns its prescaler, which restarts at frame start, so every bit is exactly 16·(i_div+1) clk.
- RX path: a 2-flop synchroniser, reset value 1, feeds the RX FSM: IDLE → START → DATA → PARITY → STOP.
  - IDLE: a synchronised 0 moves to START and restarts the RX prescaler.
  - START: resample after 8 ticks. A 1 there is a false start; return to IDLE with no push.
  - DATA: DATA_BITS samples, one every 16 ticks.
  - PARITY: one sample, only if parity enabled. A mismatch sets flag[0].
  - STOP: one sample. A 0 sets flag[1]. Only one stop bit is checked regardless of i_stop2.
  - The character and its flags are pushed at the stop sample, and the FSM returns to IDLE that cycle.
  - If the RX FIFO is full at push, the character is dropped and o_rx_overrun is set.
- Overrun: i_err_clr clears o_rx_overrun. A clear coincident with a new overrun leaves it set.
- Reset (any time, including mid-frame):
  - Both FIFOs are emptied and both FSMs go to IDLE.
  - Outputs: o_tx=1, o_tx_busy=0, o_txfifo_full=0, o_txfifo_cnt=0, o_rxfifo_empty=1, o_rxfifo_rdata=0, o_rxfifo_rerr=0, o_rxfifo_cnt=0, o_rx_overrun=0.

## Timing
- FIFO flags and counts update the clk after the wen/ren edge.
- TX latency, FIFO write to start bit: the write registers at edge N. The FSM leaves IDLE at N+1 if idle. o_tx goes low and o_tx_busy rises at N+2.
- Back-to-back TX frames: the next start bit follows the last stop bit with no idle gap when the FIFO is non-empty.
- RX latency: the character appears in the FIFO (empty falls) 3 clk after the synchronised stop-bit mid-sample tick. This includes the 2-flop synchroniser delay.
- i_div=0: one tick per clk, so a bit is 16 clk.

## Configuration
- UART_PARITY_EN defined: parity logic is built and controlled at runtime by i_parity_en/i_parity_odd.
- UART_PARITY_EN not defined: no parity hardware. i_parity_en/i_parity_odd are ignored, frames never carry a parity bit, and o_rxfifo_rerr[0] is constant 0.

## Test plan
- Write 0xA5, DATA_BITS=8, i_div=3, no parity, 1 stop -> o_tx low 64 clk, then bits 1,0,1,0,0,1,0,1 at 64 clk each, then high 64 clk; o_tx_busy falls after the stop bit.
- Loop o_tx to i_rx, even parity, i_stop2=1; send 0x00, 0xFF, 0x3C -> RX FIFO holds the same 3 bytes in order with rerr=0; TX stop bits are 128 clk at i_div=3.
- Drive i_rx with odd parity and a corrupted parity bit on 0x55 while configured even -> rdata=0x55, rerr=2'b01. Drive a stop bit of 0 -> rerr[1]=1.
- 16-clk low glitch on i_rx at i_div=3 -> no push, RX FSM back to IDLE.
- Receive FIFO_DEPTH+1 bytes without reading -> cnt=FIFO_DEPTH, last byte dropped, o_rx_overrun=1. Pulse i_err_clr -> 0.
- Assert rst mid-TX-frame with 3 bytes queued -> o_tx=1 and o_txfifo_cnt=0 immediately. After release, no further frames are sent.

Source files
------------

// File: rtl/uart_param.sv
// Parametrised UART: runtime divisor, 5..8 data bits, 1/2 stop bits, TX/RX FIFOs.
// Define UART_PARITY_EN to build the optional parity generator/checker.
module uart_param #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DIV_WIDTH-1:0]           i_div,
    input  logic                           i_parity_en,
    input  logic                           i_parity_odd,
    input  logic                           i_stop2,
    input  logic                           i_txfifo_wen,
    input  logic [DATA_BITS-1:0]           i_txfifo_wdata,
    output logic                           o_txfifo_full,
    output logic [$clog2(FIFO_DEPTH):0]    o_txfifo_cnt,
    input  logic                           i_rxfifo_ren,
    output logic                           o_rxfifo_empty,
    output logic [DATA_BITS-1:0]           o_rxfifo_rdata,
    output logic [1:0]                     o_rxfifo_rerr,
    output logic [$clog2(FIFO_DEPTH):0]    o_rxfifo_cnt,
    output logic                           o_rx_overrun,
    input  logic                           i_err_clr,
    output logic                           o_tx_busy,
    output logic                           o_tx,
    input  logic                           i_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam int RW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic cfg_par_en;
    logic cfg_par_odd;
`ifdef UART_PARITY_EN
    assign cfg_par_en  = i_parity_en;
    assign cfg_par_odd = i_parity_odd;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = i_parity_en ^ i_parity_odd;
    assign cfg_par_en     = 1'b0;
    assign cfg_par_odd    = 1'b0;
`endif

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] txf_mem [FIFO_DEPTH];
    logic [AW-1:0]        txf_wp;
    logic [AW-1:0]        txf_rp;
    logic [CW-1:0]        txf_cnt;
    logic                 txf_empty;
    logic                 txf_wr;
    logic                 txf_rd;
    logic [DATA_BITS-1:0] txf_rdata;
    logic                 tx_pop;

    assign o_txfifo_cnt  = txf_cnt;
    assign o_txfifo_full = txf_cnt == CW'(FIFO_DEPTH);
    assign txf_empty     = txf_cnt == '0;
    assign txf_wr        = i_txfifo_wen && !o_txfifo_full;
    assign txf_rd        = tx_pop && !txf_empty;
    assign txf_rdata     = txf_mem[txf_rp];

    always_ff @(posedge clk) begin
        if (txf_wr)
            txf_mem[txf_wp] <= i_txfifo_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txf_wp  <= '0;
            txf_rp  <= '0;
            txf_cnt <= '0;
        end else begin
            if (txf_wr)
                txf_wp <= txf_wp + 1'b1;
            if (txf_rd)
                txf_rp <= txf_rp + 1'b1;
            if (txf_wr && !txf_rd)
                txf_cnt <= txf_cnt + 1'b1;
            else if (txf_rd && !txf_wr)
                txf_cnt <= txf_cnt - 1'b1;
        end
    end

    // ---------------- TX engine ----------------
    state_t               tx_state;
    state_t               tx_nxt;
    logic [DATA_BITS-1:0] tx_shr;
    logic [DIV_WIDTH-1:0] tx_div;
    logic [DIV_WIDTH-1:0] tx_pre;
    logic [3:0]           tx_tcnt;
    logic [IW-1:0]        tx_idx;
    logic                 tx_sidx;
    logic                 tx_par_en;
    logic                 tx_odd;
    logic                 tx_stop2;
    logic                 tx_tick;
    logic                 tx_done;
    logic                 tx_last;
    logic                 tx_bit;

    assign tx_tick = tx_pre == tx_div;
    assign tx_done = tx_tick && (tx_tcnt == 4'd15);
    assign tx_last = tx_idx == IW'(DATA_BITS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx_state <= S_IDLE;
        else
            tx_state <= tx_nxt;
    end

    always_comb begin
        tx_nxt = tx_state;
        tx_pop = 1'b0;
        tx_bit = 1'b1;
        unique case (tx_state)
            S_IDLE: begin
                if (!txf_empty) begin
                    tx_nxt = S_START;
                    tx_pop = 1'b1;
                end
            end
            S_START: begin
                tx_bit = 1'b0;
                if (tx_done)
                    tx_nxt = S_DATA;
            end
            S_DATA: begin
                tx_bit = tx_shr[tx_idx];
                if (tx_done && tx_last)
                    tx_nxt = tx_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_bit = (^tx_shr) ^ tx_odd;
                if (tx_done)
                    tx_nxt = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next start bit when data is waiting
                if (tx_done && (tx_sidx || !tx_stop2)) begin
                    if (!txf_empty) begin
                        tx_nxt = S_START;
                        tx_pop = 1'b1;
                    end else begin
                        tx_nxt = S_IDLE;
                    end
                end
            end
            default: tx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shr    <= '0;
            tx_div    <= '0;
            tx_pre    <= '0;
            tx_tcnt   <= '0;
            tx_idx    <= '0;
            tx_sidx   <= 1'b0;
            tx_par_en <= 1'b0;
            tx_odd    <= 1'b0;
            tx_stop2  <= 1'b0;
            o_tx      <= 1'b1;
            o_tx_busy <= 1'b0;
        end else begin
            o_tx      <= tx_bit;
            o_tx_busy <= tx_state != S_IDLE;
            if (tx_pop) begin
                tx_shr    <= txf_rdata;
                tx_div    <= i_div;
                tx_par_en <= cfg_par_en;
                tx_odd    <= cfg_par_odd;
                tx_stop2  <= i_stop2;
                tx_pre    <= '0;
                tx_tcnt   <= '0;
                tx_idx    <= '0;
                tx_sidx   <= 1'b0;
            end else if (tx_state != S_IDLE) begin
                tx_pre <= tx_tick ? '0 : tx_pre + 1'b1;
                if (tx_tick)
                    tx_tcnt <= tx_tcnt + 1'b1;
                if (tx_done && tx_state == S_DATA)
                    tx_idx <= tx_idx + 1'b1;
                if (tx_done && tx_state == S_STOP)
                    tx_sidx <= 1'b1;
            end
        end
    end

    // ---------------- RX engine ----------------
    state_t               rx_state;
    state_t               rx_nxt;
    logic                 rx_s1;
    logic                 rx_s2;
    logic [DATA_BITS-1:0] rx_shr;
    logic [DIV_WIDTH-1:0] rx_div;
    logic [DIV_WIDTH-1:0] rx_pre;
    logic [3:0]           rx_tcnt;
    logic [IW-1:0]        rx_idx;
    logic                 rx_par_en;
    logic                 rx_odd;
    logic                 rx_perr;
    logic                 rx_tick;
    logic                 rx_smp;
    logic                 rx_last;
    logic                 rx_start;
    logic                 rx_push;
    logic                 rxf_full;

    assign rx_tick = rx_pre == rx_div;
    // Every sample lands on the 8th tick of a 16-tick bit window
    assign rx_smp  = rx_tick && (rx_tcnt == 4'd7);
    assign rx_last = rx_idx == IW'(DATA_BITS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= S_IDLE;
        end else begin
            rx_s1    <= i_rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_nxt;
        end
    end

    always_comb begin
        rx_nxt   = rx_state;
        rx_start = 1'b0;
        rx_push  = 1'b0;
        unique case (rx_state)
            S_IDLE: begin
                if (!rx_s2) begin
                    rx_nxt   = S_START;
                    rx_start = 1'b1;
                end
            end
            S_START: begin
                if (rx_smp)
                    rx_nxt = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (rx_smp && rx_last)
                    rx_nxt = rx_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (rx_smp)
                    rx_nxt = S_STOP;
            end
            S_STOP: begin
                if (rx_smp) begin
                    rx_nxt  = S_IDLE;
                    rx_push = 1'b1;
                end
            end
            default: rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shr    <= '0;
            rx_div    <= '0;
            rx_pre    <= '0;
            rx_tcnt   <= '0;
            rx_idx    <= '0;
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
            rx_perr   <= 1'b0;
        end else if (rx_start) begin
            rx_div    <= i_div;
            rx_par_en <= cfg_par_en;
            rx_odd    <= cfg_par_odd;
            rx_pre    <= '0;
            rx_tcnt   <= '0;
            rx_idx    <= '0;
            rx_perr   <= 1'b0;
        end else if (rx_state != S_IDLE) begin
            rx_pre <= rx_tick ? '0 : rx_pre + 1'b1;
            if (rx_tick)
                rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_smp && rx_state == S_DATA) begin
                rx_shr[rx_idx] <= rx_s2;
                rx_idx         <= rx_idx + 1'b1;
            end
            if (rx_smp && rx_state == S_PARITY)
                rx_perr <= rx_s2 ^ (^rx_shr) ^ rx_odd;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [RW-1:0] rxf_mem [FIFO_DEPTH];
    logic [AW-1:0] rxf_wp;
    logic [AW-1:0] rxf_rp;
    logic [CW-1:0] rxf_cnt;
    logic          rxf_wr;
    logic          rxf_rd;
    logic [RW-1:0] rxf_wdata;
    logic [RW-1:0] rxf_head;

    assign rxf_wdata      = {~rx_s2, rx_perr, rx_shr};
    assign o_rxfifo_cnt   = rxf_cnt;
    assign rxf_full       = rxf_cnt == CW'(FIFO_DEPTH);
    assign o_rxfifo_empty = rxf_cnt == '0;
    assign rxf_wr         = rx_push && !rxf_full;
    assign rxf_rd         = i_rxfifo_ren && !o_rxfifo_empty;
    assign rxf_head       = o_rxfifo_empty ? '0 : rxf_mem[rxf_rp];
    assign o_rxfifo_rdata = rxf_head[DATA_BITS-1:0];
    assign o_rxfifo_rerr  = rxf_head[RW-1:DATA_BITS];

    always_ff @(posedge clk) begin
        if (rxf_wr)
            rxf_mem[rxf_wp] <= rxf_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxf_wp       <= '0;
            rxf_rp       <= '0;
            rxf_cnt      <= '0;
            o_rx_overrun <= 1'b0;
        end else begin
            if (rxf_wr)
                rxf_wp <= rxf_wp + 1'b1;
            if (rxf_rd)
                rxf_rp <= rxf_rp + 1'b1;
            if (rxf_wr && !rxf_rd)
                rxf_cnt <= rxf_cnt + 1'b1;
            else if (rxf_rd && !rxf_wr)
                rxf_cnt <= rxf_cnt - 1'b1;
            if (rx_push && rxf_full)
                o_rx_overrun <= 1'b1;
            else if (i_err_clr)
                o_rx_overrun <= 1'b0;
        end
    end
endmodule
